// File: rtl/ascon_bdi_packer.sv
// Byte-to-word packer feeding the Ascon core's bdi port. Two word slots are
// used: an assembly slot that collects bytes and an output slot held stable for the core.
module ascon_bdi_packer #(
  parameter int CCW   = 32,
  parameter int BYTES = CCW / 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     in_type,
  input  logic           in_last,
  input  logic           in_eoi,
  output logic [CCW-1:0] bdi,
  output logic           bdi_valid,
  input  logic           bdi_ready,
  output logic [3:0]     bdi_valid_bytes,
  output logic [3:0]     bdi_type,
  output logic           bdi_eot,
  output logic           bdi_eoi,
  output logic           err
);

  // Assembly slot
  logic [CCW-1:0] asm_data;
  logic [2:0]     asm_cnt;
  logic [3:0]     asm_type;
  logic           asm_eot;
  logic           asm_eoi;
  logic           asm_full;

  // Holds in_ready low until the first clock after reset is released
  logic           alive;
  logic           eoi_done;

  logic           out_free;
  logic           move;
  logic           accept;
  logic           drop;
  logic           err_set;
  logic           write;
  logic           bypass;
  logic [CCW-1:0] base_data;
  logic [2:0]     base_cnt;
  logic [CCW-1:0] nxt_data;
  logic [2:0]     nxt_cnt;
  logic [3:0]     nxt_type;
  logic           nxt_full;
  logic           nxt_eoi;

  function automatic logic [3:0] lane_mask(input logic [2:0] cnt);
    lane_mask = 4'((5'd1 << cnt) - 5'd1);
  endfunction

  assign out_free = ~bdi_valid | bdi_ready;
  assign move     = asm_full & out_free;
  assign in_ready = alive & ~flush & (~asm_full | out_free);
  assign accept   = in_valid & in_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    base_data = asm_data;
    base_cnt  = asm_cnt;
    if (move) begin
      base_data = '0;
      base_cnt  = '0;
    end

    nxt_data = base_data;
    for (int k = 0; k < BYTES; k++) begin
      if (base_cnt == 3'(k)) nxt_data[8*k +: 8] = in_data;
    end
    nxt_cnt  = base_cnt + 3'd1;
    nxt_type = (base_cnt == 3'd0) ? in_type : asm_type;
    nxt_full = (nxt_cnt == 3'(BYTES)) | in_last;
    // An eoi without a last is downgraded to an ordinary byte
    nxt_eoi  = in_last & in_eoi;

    drop    = eoi_done | ((base_cnt != 3'd0) && (in_type != asm_type));
    err_set = accept & (drop | (in_eoi & ~in_last));
    write   = accept & ~drop;
    // A completed word skips the assembly slot when the output slot can take it now
    bypass  = write & nxt_full & out_free & ~asm_full;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive           <= 1'b0;
      asm_data        <= '0;
      asm_cnt         <= '0;
      asm_type        <= '0;
      asm_eot         <= 1'b0;
      asm_eoi         <= 1'b0;
      asm_full        <= 1'b0;
      eoi_done        <= 1'b0;
      err             <= 1'b0;
      bdi             <= '0;
      bdi_valid       <= 1'b0;
      bdi_valid_bytes <= '0;
      bdi_type        <= '0;
      bdi_eot         <= 1'b0;
      bdi_eoi         <= 1'b0;
    end else if (flush) begin
      asm_data  <= '0;
      asm_cnt   <= '0;
      asm_type  <= '0;
      asm_eot   <= 1'b0;
      asm_eoi   <= 1'b0;
      asm_full  <= 1'b0;
      eoi_done  <= 1'b0;
      err       <= 1'b0;
      bdi_valid <= 1'b0;
    end else begin
      alive <= 1'b1;

      if (bdi_valid && bdi_ready) bdi_valid <= 1'b0;

      if (move) begin
        bdi             <= asm_data;
        bdi_valid       <= 1'b1;
        bdi_valid_bytes <= lane_mask(asm_cnt);
        bdi_type        <= asm_type;
        bdi_eot         <= asm_eot;
        bdi_eoi         <= asm_eoi;
        asm_data        <= '0;
        asm_cnt         <= '0;
        asm_eot         <= 1'b0;
        asm_eoi         <= 1'b0;
        asm_full        <= 1'b0;
      end

      if (bypass) begin
        bdi             <= nxt_data;
        bdi_valid       <= 1'b1;
        bdi_valid_bytes <= lane_mask(nxt_cnt);
        bdi_type        <= nxt_type;
        bdi_eot         <= in_last;
        bdi_eoi         <= nxt_eoi;
        asm_data        <= '0;
        asm_cnt         <= '0;
        asm_eot         <= 1'b0;
        asm_eoi         <= 1'b0;
        asm_full        <= 1'b0;
      end else if (write) begin
        asm_data <= nxt_data;
        asm_cnt  <= nxt_cnt;
        asm_type <= nxt_type;
        asm_full <= nxt_full;
        asm_eot  <= in_last;
        asm_eoi  <= nxt_eoi;
      end

      if (write && nxt_eoi) eoi_done <= 1'b1;
      if (err_set)          err      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ascon_bdi_packer.sv
// Directed bench for ascon_bdi_packer: byte streams with hand-computed words,
// backpressure, type/eoi errors, flush and asynchronous reset.
module tb_ascon_bdi_packer;

  localparam logic [3:0] D_NONCE = 4'h1;
  localparam logic [3:0] D_AD    = 4'h2;
  localparam logic [3:0] D_MSG   = 4'h4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  vb;
    logic [3:0]  typ;
    logic        eot;
    logic        eoi;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_type;
  logic        in_last;
  logic        in_eoi;
  logic [31:0] bdi;
  logic        bdi_valid;
  logic        bdi_ready;
  logic [3:0]  bdi_valid_bytes;
  logic [3:0]  bdi_type;
  logic        bdi_eot;
  logic        bdi_eoi;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  word_t q[$];

  ascon_bdi_packer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_last(in_last), .in_eoi(in_eoi),
    .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready),
    .bdi_valid_bytes(bdi_valid_bytes), .bdi_type(bdi_type),
    .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi), .err(err)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so the negedge sees the values that the next edge uses
  always @(negedge clk) begin
    if (!rst && !flush && bdi_valid && bdi_ready)
      q.push_back('{bdi, bdi_valid_bytes, bdi_type, bdi_eot, bdi_eoi});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] t, input logic l, input logic e);
    bit done = 0;
    in_data  = d;
    in_type  = t;
    in_last  = l;
    in_eoi   = e;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_eoi   = 1'b0;
    if (!done) check("send_accept", 32'(done), 32'd1);
  endtask

  task automatic check_word(input string tag, input word_t exp);
    word_t w;
    if (q.size() == 0) begin
      check({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      w = q.pop_front();
      check({tag, "_data"}, w.data, exp.data);
      check({tag, "_vb"}, 32'(w.vb), 32'(exp.vb));
      check({tag, "_type"}, 32'(w.typ), 32'(exp.typ));
      check({tag, "_eot"}, 32'(w.eot), 32'(exp.eot));
      check({tag, "_eoi"}, 32'(w.eoi), 32'(exp.eoi));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0; in_type = '0;
    in_last = 1'b0; in_eoi = 1'b0; bdi_ready = 1'b0;

    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_bdi_valid", 32'(bdi_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_bdi", bdi, 32'd0);
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rel_in_ready_high", 32'(in_ready), 32'd1);

    // 5-byte AD stream
    bdi_ready = 1'b1;
    q.delete();
    for (int i = 1; i <= 5; i++) send(8'(i), D_AD, i == 5, 1'b0);
    idle(3);
    check("ad5_count", 32'(q.size()), 32'd2);
    check_word("ad5_w0", '{32'h04030201, 4'b1111, D_AD, 1'b0, 1'b0});
    check_word("ad5_w1", '{32'h00000005, 4'b0001, D_AD, 1'b1, 1'b0});

    // 12 bytes back to back: a word every 4th cycle, in_ready never drops
    q.delete();
    for (int i = 0; i < 12; i++) begin
      in_data = 8'(8'h20 + i); in_type = D_MSG; in_last = (i == 11); in_eoi = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("b2b_in_ready_%0d", i), 32'(in_ready), 32'd1);
      check($sformatf("b2b_valid_%0d", i), 32'(bdi_valid), 32'((i == 4) || (i == 8)));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("b2b_valid_12", 32'(bdi_valid), 32'd1);
    idle(2);
    check("b2b_count", 32'(q.size()), 32'd3);
    check_word("b2b_w0", '{32'h23222120, 4'b1111, D_MSG, 1'b0, 1'b0});
    check_word("b2b_w1", '{32'h27262524, 4'b1111, D_MSG, 1'b0, 1'b0});
    check_word("b2b_w2", '{32'h2b2a2928, 4'b1111, D_MSG, 1'b1, 1'b0});

    // Type change mid-word: dropped, err set, word continues
    q.delete();
    send(8'hAA, D_AD, 1'b0, 1'b0);
    send(8'hBB, D_AD, 1'b0, 1'b0);
    send(8'hCC, D_MSG, 1'b0, 1'b0);
    idle(1);
    check("type_err", 32'(err), 32'd1);
    check("type_no_word", 32'(bdi_valid), 32'd0);
    send(8'hDD, D_AD, 1'b1, 1'b0);
    idle(2);
    check("type_count", 32'(q.size()), 32'd1);
    check_word("type_w", '{32'h00DDBBAA, 4'b0111, D_AD, 1'b1, 1'b0});
    check("type_err_sticky", 32'(err), 32'd1);

    // Flush with a pending word: word discarded, err cleared
    q.delete();
    bdi_ready = 1'b0;
    send(8'h55, D_AD, 1'b1, 1'b0);
    check("fl_pending", 32'(bdi_valid), 32'd1);
    check("fl_pending_bdi", bdi, 32'h00000055);
    flush = 1'b1; bdi_ready = 1'b1;
    @(negedge clk);
    check("fl_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("fl_valid", 32'(bdi_valid), 32'd0);
    check("fl_err", 32'(err), 32'd0);
    send(8'h42, D_AD, 1'b1, 1'b0);
    idle(2);
    check("fl_count", 32'(q.size()), 32'd1);
    check_word("fl_w", '{32'h00000042, 4'b0001, D_AD, 1'b1, 1'b0});

    // 8-byte MSG with backpressure; both slots fill and in_ready drops
    q.delete();
    bdi_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i), D_MSG, i == 7, i == 7);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_valid", 32'(bdi_valid), 32'd1);
    check("bp_bdi", bdi, 32'h13121110);
    idle(3);
    check("bp_bdi_stable", bdi, 32'h13121110);
    check("bp_vb_stable", 32'(bdi_valid_bytes), 32'hF);
    check("bp_in_ready_hold", 32'(in_ready), 32'd0);
    bdi_ready = 1'b1;
    idle(3);
    check("bp_count", 32'(q.size()), 32'd2);
    check_word("bp_w0", '{32'h13121110, 4'b1111, D_MSG, 1'b0, 1'b0});
    check_word("bp_w1", '{32'h17161514, 4'b1111, D_MSG, 1'b1, 1'b1});
    check("bp_err", 32'(err), 32'd0);

    // Byte after eoi: dropped, err set
    q.delete();
    send(8'h77, D_AD, 1'b1, 1'b0);
    idle(2);
    check("post_eoi_err", 32'(err), 32'd1);
    check("post_eoi_dropped", 32'(q.size()), 32'd0);

    // Asynchronous reset mid-word
    send(8'h61, D_NONCE, 1'b0, 1'b0);
    send(8'h62, D_NONCE, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_bdi", bdi, 32'd0);
    check("arst_valid", 32'(bdi_valid), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_meta", {24'd0, bdi_valid_bytes, bdi_type}, 32'd0);
    check("arst_flags", {30'd0, bdi_eot, bdi_eoi}, 32'd0);
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check("arst_rel_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("arst_rel_high", 32'(in_ready), 32'd1);
    q.delete();
    for (int i = 0; i < 4; i++) send(8'(8'h80 + i), D_NONCE, i == 3, 1'b0);
    idle(2);
    check("nonce_count", 32'(q.size()), 32'd1);
    check_word("nonce_w", '{32'h83828180, 4'b1111, D_NONCE, 1'b1, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_bdi_packer.md
Name: ascon_bdi_packer

Overview:
- Upstream feeder for the Ascon core's block-data input. Accepts a byte stream tagged with a data type, and packs it into 32-bit words on the core's bdi interface.
- Drives the core's bdi, bdi_valid, bdi_valid_bytes, bdi_type, bdi_eot and bdi_eoi, and honours its bdi_ready.
- Byte order: the first byte of a word goes to bdi[7:0]; valid bytes are contiguous from the LSB.
- Two word slots (an assembly slot and an output slot) sustain one byte per cycle.

Parameters:
- CCW, 32, bdi word width; only 32 is supported.
- BYTES, CCW/8, bytes per word.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous clear; drops all buffered data
- in_data  in  8  input byte
- in_valid  in  1  byte valid
- in_ready  out  1  byte accepted when in_valid & in_ready
- in_type  in  4  type of the byte (D_AD, D_MSG, D_NONCE, D_TAG encodings)
- in_last  in  1  last byte of the current type segment
- in_eoi  in  1  last byte of the whole input; valid only with in_last
- bdi  out  CCW  packed word
- bdi_valid  out  1  word valid
- bdi_ready  in  1  core accepts the word
- bdi_valid_bytes  out  4  one of 0001, 0011, 0111 or 1111
- bdi_type  out  4  type of the word
- bdi_eot  out  1  word ends its segment
- bdi_eoi  out  1  word ends the input
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst=1): all outputs are 0, both slots are empty, the byte counter is 0, err=0, and in_ready=0 while rst is held. in_ready rises in the first cycle after rst is released.
- Assembly slot:
  - Holds asm_data, asm_cnt (0..4), asm_type, asm_eot, asm_eoi and asm_full.
  - On an accepted byte, the byte is written to lane asm_cnt, so byte k goes to bits 8k+7:8k.
  - asm_type is latched from the first byte of each word.
  - The word becomes asm_full when asm_cnt reaches 4, or when the accepted byte has in_last=1. In that case asm_eot=in_last and asm_eoi=in_last&in_eoi.
  - Unwritten lanes read as 0.
- Output slot:
  - When out_valid=0, or out_valid&bdi_ready, and asm_full=1: the assembly word moves to the output slot and the assembly slot empties.
  - bdi_valid_bytes = (1<<cnt)-1.
  - A full word is 4 bytes; an N-byte word carries cnt=N.
  - bdi, bdi_valid_bytes, bdi_type, bdi_eot and bdi_eoi stay stable while bdi_valid & ~bdi_ready.
- in_ready:
  - in_ready = ~asm_full | (~out_valid | bdi_ready).
  - If a move and a byte acceptance happen in the same cycle, the byte goes into lane 0 of the freshly emptied slot.
- Latency and throughput:
  - A byte that completes a word in cycle N gives bdi_valid=1 in cycle N+1 when the output slot is free.
  - Sustained rate is 1 byte/cycle with bdi_ready held at 1.
- Type rule:
  - A byte whose in_type differs from asm_type while asm_cnt>0 sets err=1. That byte is dropped (still acknowledged) and the word is unchanged.
  - A type change is legal only after in_last.
- Other protocol errors:
  - in_eoi=1 with in_last=0 sets err=1; the byte is treated as in_last=0, in_eoi=0.
  - Any byte accepted after an eoi word, before flush or reset, sets err=1 and is dropped.
- err is sticky and is cleared only by rst or flush.
- flush:
  - Highest priority among synchronous events.
  - Empties both slots, zeroes the counter and clears err.
  - bdi_valid=0 in the next cycle, even if bdi_ready=1 in the flush cycle; the word is considered not transferred.
  - in_ready=0 during the flush cycle.
- Reset mid-operation: the same clearing as flush, applied immediately and asynchronously.

Test Plan:
- 5-byte AD stream 0x01..0x05 with in_last on 0x05, in_type=D_AD, bdi_ready=1 -> word0: bdi=0x04030201, valid_bytes=1111, eot=0; word1: bdi=0x00000005, valid_bytes=0001, eot=1, type=D_AD.
- 8-byte MSG stream 0x10..0x17 with in_last and in_eoi on the last byte, bdi_ready held at 0 for 6 cycles, then 1 -> in_ready drops after the 8th byte is needed while both slots are full; words 0x13121110 (eot=0) and 0x17161514 (eot=1, eoi=1) are delivered stable and in order with no loss.
- Back-to-back 12 bytes with bdi_ready=1 -> in_ready stays 1 throughout, and bdi_valid is asserted every 4th cycle starting 1 cycle after byte 4.
- AD bytes 0xAA,0xBB, then a MSG byte 0xCC with no in_last -> err=1, 0xCC is dropped, and the AD word stays in assembly at cnt=2. Then AD byte 0xDD with in_last -> bdi=0x00DDBBAA, valid_bytes=0111.
- Output word pending with bdi_ready=0, then flush=1 for one cycle -> the next cycle has bdi_valid=0 and err=0; the next byte 0x42 with in_last gives bdi=0x00000042, valid_bytes=0001.
- rst asserted asynchronously mid-word -> all outputs are 0 immediately; after release, in_ready=1 and a 4-byte NONCE word packs correctly from lane 0.
